// File: rtl/spi_pkg.sv
// Shared widths, counter sizing and FSM states
// for the SPI slave receive path.
package spi_pkg;
  localparam int FRAME_W = 17;
  localparam int HDR_W   = 9;
  localparam int DATA_W  = FRAME_W - HDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an async pin with
// single-cycle rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;
endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversampled frame receive with
// parallel header/data delivery and miso response.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl,
  input  logic               ss,
  input  logic               mosi,
  output logic               miso,
  input  logic [FRAME_W-1:0] tx_word,
  input  logic               tx_valid,
  output logic               tx_taken,
  output logic [HDR_W-1:0]   rx_hdr,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);
  logic scl_rise, scl_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s, last_bit;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
  logic               miso_q, miso_d;
  logic               taken_q, taken_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               rxv_q, rxv_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               ss_hi_q, ss_hi_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ss),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // Same depth as the scl chain keeps mosi aligned to the fall pulse.
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign last_bit = scl_fall && (cnt_q == CNT_W'(FRAME_W - 1));
  assign ss_hi_d  = ss_rise ? 1'b1 : (ss_fall ? 1'b0 : ss_hi_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_sr_d = rx_sr_q;
    tx_sr_d = tx_sr_q;
    miso_d  = miso_q;
    taken_d = 1'b0;
    hdr_d   = hdr_q;
    data_d  = data_q;
    rxv_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rx_sr_d = '0;
          tx_sr_d = tx_valid ? tx_word : '0;
          taken_d = tx_valid;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(FRAME_W)) begin
          hdr_d   = rx_sr_q[FRAME_W-1:DATA_W];
          data_d  = rx_sr_q[DATA_W-1:0];
          rxv_d   = 1'b1;
          miso_d  = 1'b0;
          // ss may already have risen alongside the final bit
          state_d = (ss_hi_q || ss_rise) ? IDLE : DONE;
        end else begin
          if (scl_fall) begin
            rx_sr_d = {rx_sr_q[FRAME_W-2:0], mosi_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (scl_rise) begin
            miso_d  = tx_sr_q[FRAME_W-1];
            tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
          end
          if (ss_rise && !last_bit) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            miso_d  = 1'b0;
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
      miso_q  <= 1'b0;
      taken_q <= 1'b0;
      hdr_q   <= '0;
      data_q  <= '0;
      rxv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      ss_hi_q <= 1'b0;
    end else begin
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], mosi};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
      miso_q  <= miso_d;
      taken_q <= taken_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      rxv_q   <= rxv_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      ss_hi_q <= ss_hi_d;
    end
  end

  assign miso      = miso_q;
  assign tx_taken  = taken_q;
  assign rx_hdr    = hdr_q;
  assign rx_data   = data_q;
  assign rx_valid  = rxv_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: frames driven
// at pin level, rx words checked as they emerge.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int HP = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               scl = 1'b0;
  logic               ss = 1'b1;
  logic               mosi = 1'b0;
  logic               miso;
  logic [FRAME_W-1:0] tx_word = '0;
  logic               tx_valid = 1'b0;
  logic               tx_taken;
  logic [HDR_W-1:0]   rx_hdr;
  logic [DATA_W-1:0]  rx_data;
  logic               rx_valid;
  logic               frame_err;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int n_rxv = 0;
  int n_ferr = 0;
  int n_taken = 0;

  logic [FRAME_W-1:0] exp_q[$];
  logic [FRAME_W-1:0] last_exp = '0;
  logic [FRAME_W-1:0] mon_e;

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .tx_word   (tx_word),
    .tx_valid  (tx_valid),
    .tx_taken  (tx_taken),
    .rx_hdr    (rx_hdr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_taken) n_taken++;
    if (frame_err) n_ferr++;
    if (rx_valid) begin
      n_rxv++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got hdr=%h data=%h, none expected",
                 rx_hdr, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rx_hdr, rx_data} !== mon_e) begin
          errors++;
          $display("FAIL rx_word: got %h_%h expected %h_%h",
                   rx_hdr, rx_data, mon_e[FRAME_W-1:DATA_W],
                   mon_e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic run_frame(input logic [FRAME_W-1:0] w, input int ncyc,
                           input bit raise, input bit push,
                           output logic [18:0] mb);
    mb = '0;
    if (push) begin
      exp_q.push_back(w);
      last_exp = w;
    end
    @(negedge clk) ss = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < ncyc; i++) begin
      mosi = (i < FRAME_W) ? w[FRAME_W-1-i] : 1'b0;
      scl = 1'b1;
      repeat (HP) @(negedge clk);
      scl = 1'b0;
      mb[18-i] = miso;
      repeat (HP) @(negedge clk);
    end
    if (raise) begin
      ss = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({miso, tx_taken, rx_valid, frame_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {miso, tx_taken, rx_valid, frame_err, busy});
    end
    checks++;
    if ({rx_hdr, rx_data} !== '0) begin
      errors++;
      $display("FAIL reset_rx: got %h_%h expected 0", rx_hdr, rx_data);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single;
    logic [18:0] mb;
    int r0, f0;
    r0 = n_rxv;
    f0 = n_ferr;
    run_frame(17'b011101001_00011001, 19, 1'b1, 1'b1, mb);
    checks++;
    if (n_rxv - r0 !== 1) begin
      errors++;
      $display("FAIL single_rxv_count: got %0d expected 1", n_rxv - r0);
    end
    checks++;
    if (n_ferr - f0 !== 0) begin
      errors++;
      $display("FAIL single_ferr: got %0d expected 0", n_ferr - f0);
    end
    checks++;
    if (rx_hdr !== 9'h0E9 || rx_data !== 8'h19) begin
      errors++;
      $display("FAIL single_out: got %h_%h expected 0e9_19", rx_hdr, rx_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [18:0] mb;
    int r0;
    r0 = n_rxv;
    run_frame(17'b011101001_00011001, 19, 1'b1, 1'b1, mb);
    run_frame(17'b010101011_00011001, 19, 1'b1, 1'b1, mb);
    checks++;
    if (n_rxv - r0 !== 2) begin
      errors++;
      $display("FAIL b2b_rxv_count: got %0d expected 2", n_rxv - r0);
    end
    checks++;
    if (rx_hdr !== 9'h0AB || rx_data !== 8'h19) begin
      errors++;
      $display("FAIL b2b_out: got %h_%h expected 0ab_19", rx_hdr, rx_data);
    end
  endtask

  task automatic test_tx;
    logic [18:0] mb;
    int t0;
    t0 = n_taken;
    tx_word = 17'h1A5A5;
    tx_valid = 1'b1;
    run_frame({9'h123, 8'h45}, 19, 1'b1, 1'b1, mb);
    tx_valid = 1'b0;
    checks++;
    if (n_taken - t0 !== 1) begin
      errors++;
      $display("FAIL tx_taken_count: got %0d expected 1", n_taken - t0);
    end
    checks++;
    if (mb !== {17'h1A5A5, 2'b00}) begin
      errors++;
      $display("FAIL tx_miso: got %b expected %b", mb, {17'h1A5A5, 2'b00});
    end
  endtask

  task automatic test_frame_err;
    logic [18:0] mb;
    int r0, f0;
    r0 = n_rxv;
    f0 = n_ferr;
    run_frame({9'h1C3, 8'h3C}, 10, 1'b0, 1'b0, mb);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL err_busy_mid: got %b expected 1", busy);
    end
    ss = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL err_busy_after: got %b expected 0", busy);
    end
    run_frame({9'h0F0, 8'hF0}, 16, 1'b1, 1'b0, mb);
    checks++;
    if (n_ferr - f0 !== 2) begin
      errors++;
      $display("FAIL err_count: got %0d expected 2", n_ferr - f0);
    end
    checks++;
    if (n_rxv - r0 !== 0) begin
      errors++;
      $display("FAIL err_rxv: got %0d expected 0", n_rxv - r0);
    end
    checks++;
    if ({rx_hdr, rx_data} !== last_exp) begin
      errors++;
      $display("FAIL err_hold: got %h_%h expected %h", rx_hdr, rx_data, last_exp);
    end
  endtask

  task automatic test_reset_mid;
    logic [18:0] mb;
    int r0, f0;
    r0 = n_rxv;
    f0 = n_ferr;
    run_frame({9'h155, 8'hAA}, 8, 1'b0, 1'b0, mb);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, tx_taken, rx_valid, frame_err, busy} !== 5'b0 ||
        {rx_hdr, rx_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs: got %b %h_%h expected all 0",
               {miso, tx_taken, rx_valid, frame_err, busy}, rx_hdr, rx_data);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      scl = 1'b1;
      repeat (HP) @(negedge clk);
      scl = 1'b0;
      repeat (HP) @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_low_ss: got %b expected 0", busy);
    end
    ss = 1'b1;
    repeat (12) @(negedge clk);
    run_frame({9'h0C5, 8'h7E}, 19, 1'b1, 1'b1, mb);
    checks++;
    if (n_rxv - r0 !== 1 || n_ferr - f0 !== 0) begin
      errors++;
      $display("FAIL mid_counts: got rxv=%0d ferr=%0d expected 1 0",
               n_rxv - r0, n_ferr - f0);
    end
    checks++;
    if (rx_hdr !== 9'h0C5 || rx_data !== 8'h7E) begin
      errors++;
      $display("FAIL mid_out: got %h_%h expected 0c5_7e", rx_hdr, rx_data);
    end
  endtask

  task automatic test_no_tx;
    logic [18:0] mb;
    int t0;
    t0 = n_taken;
    tx_word = '1;
    tx_valid = 1'b0;
    run_frame({9'h1FF, 8'h00}, 19, 1'b1, 1'b1, mb);
    checks++;
    if (n_taken - t0 !== 0) begin
      errors++;
      $display("FAIL notx_taken: got %0d expected 0", n_taken - t0);
    end
    checks++;
    if (mb !== 19'b0) begin
      errors++;
      $display("FAIL notx_miso: got %b expected 0", mb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx();
    test_frame_err();
    test_reset_mid();
    test_no_tx();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
